program_store: RTL and testbench
================================

Name: program_store

Overview:
- Parametrised, run-time loadable successor to the fixed ROM program memory for picoMips-class cores.
- Holds DEPTH instruction words in a synchronous RAM, not a hard-coded case table.
- Provides a registered fetch port with stall, plus a valid/ready loader port so a program can be downloaded without resynthesis.
- Locations left unwritten by a load are back-filled with NOP, so the core always fetches defined words.

Parameters:
- AW, 5: fetch/load address width.
- IW, 10: instruction word width.
- DEPTH, 32: number of stored words; legal range 2 to 2**AW.
- NOP_WORD, 0: IW-bit value returned when invalid and written by back-fill.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- nReset  in  1  asynchronous active-low reset.
- Addr  in  AW  fetch address from the core PC.
- Stall  in  1  when 1, hold Instruction/InstrValid unchanged.
- Instruction  out  IW  registered fetched word.
- InstrValid  out  1  Instruction comes from a RUN-state read.
- LoadStart  in  1  one-cycle request to begin a new download.
- LoadData  in  IW  word to write.
- LoadValid  in  1  LoadData valid.
- LoadLast  in  1  qualifies LoadData as the final word of the download.
- LoadReady  out  1  block accepts a word this cycle.
- Loading  out  1  1 in LOAD or FILL.
- LoadCount  out  AW+1  words accepted in the current/last download.

Behaviour:
- Reset (async, nReset=0):
  - state=EMPTY; Instruction=NOP_WORD; InstrValid=0; LoadReady=0; Loading=0; LoadCount=0; write pointer=0.
  - RAM contents are not reset and are treated as undefined.
- FSM states: EMPTY, LOAD, FILL, RUN.
- EMPTY:
  - Instruction=NOP_WORD, InstrValid=0.
  - LoadStart -> LOAD, pointer=0, LoadCount=0.
- LOAD:
  - LoadReady=1 combinationally while in LOAD.
  - Accept = LoadValid & LoadReady: write LoadData at pointer; pointer+1; LoadCount+1.
  - Accept with LoadLast and pointer<DEPTH-1 -> FILL, pointer advanced.
  - Accept at pointer=DEPTH-1 (LoadLast or not) -> RUN; no wrap, no fill.
  - LoadStart in LOAD restarts: pointer=0, LoadCount=0, data presented that cycle is discarded. LoadStart takes priority over LoadValid.
- FILL:
  - LoadReady=0.
  - Writes NOP_WORD at pointer, one word per cycle, until DEPTH-1 is written, then -> RUN.
  - Duration is DEPTH-LoadCount cycles.
  - LoadStart in FILL -> LOAD (restart); unfilled words stay undefined until the next load completes.
- RUN fetch:
  - 1-cycle latency. If !Stall: Instruction <= mem[Addr], InstrValid <= 1.
  - Addr >= DEPTH returns NOP_WORD with InstrValid=1.
  - Stall=1 holds both outputs exactly; Addr is ignored that cycle.
- First fetch after entering RUN:
  - Addr sampled on the first RUN cycle; data appears on the next edge.
  - InstrValid stays 0 until that edge.
- LoadStart in RUN:
  - -> LOAD on the next edge.
  - Instruction forced to NOP_WORD and InstrValid=0 from that edge, regardless of Stall.
- Outside RUN: Instruction=NOP_WORD, InstrValid=0; Stall and Addr are ignored.
- No read-during-write hazard: fetch and write never share a state.
- LoadCount saturates at DEPTH and holds its value in RUN.

Decomposition:
- Shared package program_store_pkg:
  - state enum (EMPTY, LOAD, FILL, RUN);
  - default NOP_WORD constant;
  - helper function returning the count width for a given AW.
- One sub-module, prog_ram:
  - DEPTH x IW RAM, one synchronous write port and one synchronous read port, no reset;
  - infers block/distributed RAM.
- FSM, pointer, fill logic and output muxing live in program_store.

Test Plan:
- Reset, then LoadStart, then 32 words with values 0x3FF-i back-to-back, LoadLast on the 32nd:
  - -> LoadCount=32, no FILL cycles, RUN.
  - Addr=5 fetch -> Instruction=0x3FA, InstrValid=1 one cycle later.
- Short load of 3 words 0x101,0x102,0x103 with LoadLast on the third:
  - -> Loading=1 for exactly 29 FILL cycles.
  - Then Addr=2 -> 0x103, Addr=3 -> 0x000, Addr=31 -> 0x000.
- RUN, Addr stepping 0..4, Stall=1 on the cycle Addr=2 is presented:
  - -> Instruction holds the word for Addr=1 for one extra cycle.
  - Sequence continues 2,3,4 with no word skipped.
- LoadStart issued mid-load after 10 words:
  - -> LoadCount returns to 0.
  - Subsequent 4-word load plus fill yields words 0..3 new and 4..31 = 0x000.
- nReset asserted during FILL:
  - -> outputs immediately NOP_WORD, InstrValid=0, Loading=0.
  - Fetch ignored until a new load completes.
- DEPTH=20, AW=5:
  - Full 20-word load -> RUN.
  - Addr=25 -> Instruction=0x000 with InstrValid=1.

Source files
------------

// File: rtl/program_store_pkg.sv
// Shared types and constants for the loadable program store.
package program_store_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int NOP_DEFAULT = 0;

  // LoadCount must reach DEPTH, which can be 2**AW.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/program_store_ram.sv
// DEPTH x IW storage: one synchronous write port, one synchronous read port, no reset.
module prog_ram #(
  parameter int AW    = 5,
  parameter int IW    = 10,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/program_store.sv
// Run-time loadable instruction memory: valid/ready loader with NOP back-fill and a stallable fetch port.
module program_store
  import program_store_pkg::*;
#(
  parameter int            AW       = 5,
  parameter int            IW       = 10,
  parameter int            DEPTH    = 32,
  parameter logic [IW-1:0] NOP_WORD = IW'(NOP_DEFAULT)
) (
  input  logic                      Clock,
  input  logic                      nReset,
  input  logic [AW-1:0]             Addr,
  input  logic                      Stall,
  output logic [IW-1:0]             Instruction,
  output logic                      InstrValid,
  input  logic                      LoadStart,
  input  logic [IW-1:0]             LoadData,
  input  logic                      LoadValid,
  input  logic                      LoadLast,
  output logic                      LoadReady,
  output logic                      Loading,
  output logic [cnt_width(AW)-1:0]  LoadCount
);

  localparam int            CW       = cnt_width(AW);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ivld_q, ivld_d;
  logic          oob_q, oob_d;

  logic          we, re, in_range;
  logic [IW-1:0] wdata, rdata;

  assign in_range = {1'b0, Addr} < DEPTH_C;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ivld_d  = ivld_q;
    oob_d   = oob_q;
    we      = 1'b0;
    re      = 1'b0;
    wdata   = LoadData;
    case (state_q)
      ST_EMPTY: begin
        ivld_d = 1'b0;
        if (LoadStart) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        ivld_d = 1'b0;
        if (LoadStart) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (LoadValid) begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          // A word landing in the top slot ends the download outright.
          if (ptr_q == LAST_PTR) begin
            state_d = ST_RUN;
          end else begin
            ptr_d = ptr_q + AW'(1);
            if (LoadLast) state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        ivld_d = 1'b0;
        if (LoadStart) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end else begin
          we    = 1'b1;
          wdata = NOP_WORD;
          if (ptr_q == LAST_PTR) state_d = ST_RUN;
          else                   ptr_d   = ptr_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (LoadStart) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          ivld_d  = 1'b0;
        end else if (!Stall) begin
          // Out-of-range fetches leave the RAM idle and are masked to NOP.
          ivld_d = 1'b1;
          oob_d  = !in_range;
          re     = in_range;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ivld_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ivld_q  <= ivld_d;
      oob_q   <= oob_d;
    end
  end

  prog_ram #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) u_ram (
    .clk   (Clock),
    .we    (we),
    .waddr (ptr_q),
    .wdata (wdata),
    .re    (re),
    .raddr (Addr),
    .rdata (rdata)
  );

  assign Instruction = (ivld_q && !oob_q) ? rdata : NOP_WORD;
  assign InstrValid  = ivld_q;
  assign LoadReady   = (state_q == ST_LOAD);
  assign Loading     = (state_q == ST_LOAD) || (state_q == ST_FILL);
  assign LoadCount   = cnt_q;

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: scoreboarded fetches plus load/fill/reset checks, incl. a DEPTH=20 instance.
module tb_program_store;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [4:0] Addr = '0;
  logic       Stall = 1'b0;
  logic       LoadStart = 1'b0;
  logic [9:0] LoadData = '0;
  logic       LoadValid = 1'b0;
  logic       LoadLast = 1'b0;

  logic [9:0] Instruction, s_Instruction;
  logic       InstrValid, s_InstrValid;
  logic       LoadReady, s_LoadReady;
  logic       Loading, s_Loading;
  logic [5:0] LoadCount, s_LoadCount;

  program_store dut (
    .Clock(Clock), .nReset(nReset), .Addr(Addr), .Stall(Stall),
    .Instruction(Instruction), .InstrValid(InstrValid),
    .LoadStart(LoadStart), .LoadData(LoadData), .LoadValid(LoadValid),
    .LoadLast(LoadLast), .LoadReady(LoadReady), .Loading(Loading),
    .LoadCount(LoadCount)
  );

  program_store #(.DEPTH(20)) dut20 (
    .Clock(Clock), .nReset(nReset), .Addr(Addr), .Stall(Stall),
    .Instruction(s_Instruction), .InstrValid(s_InstrValid),
    .LoadStart(LoadStart), .LoadData(LoadData), .LoadValid(LoadValid),
    .LoadLast(LoadLast), .LoadReady(s_LoadReady), .Loading(s_Loading),
    .LoadCount(s_LoadCount)
  );

  always #5 Clock = ~Clock;

  typedef struct { logic [9:0] ins; logic vld; } exp_t;
  exp_t       sb[$];
  exp_t       last_exp;
  logic [9:0] mdl [32];
  logic [9:0] ld_buf [32];
  int         errs = 0;
  int         checks = 0;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expectation is pushed with the stimulus and popped when the output edge arrives.
  task automatic fetch(input logic [4:0] a, input logic st, input string tag);
    exp_t e, got;
    Addr  = a;
    Stall = st;
    if (st) e = last_exp;
    else    e = '{ins: mdl[a], vld: 1'b1};
    sb.push_back(e);
    step();
    Stall = 1'b0;
    got = sb.pop_front();
    chk({tag, "_ins"}, 16'(Instruction), 16'(got.ins));
    chk({tag, "_vld"}, 16'(InstrValid), 16'(got.vld));
    last_exp = got;
  endtask

  task automatic load(input int n, input bit start);
    if (start) begin
      LoadStart = 1'b1;
      step();
      LoadStart = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      LoadData  = ld_buf[i];
      LoadValid = 1'b1;
      LoadLast  = (i == n - 1);
      chk("load_ready", 16'(LoadReady), 16'd1);
      step();
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = (i < n) ? ld_buf[i] : 10'h000;
    chk("load_count", 16'(LoadCount), 16'(n));
  endtask

  task automatic wait_fill(input int exp_cycles);
    int n = 0;
    while (Loading && n < 100) begin
      n++;
      step();
    end
    chk("fill_cycles", 16'(n), 16'(exp_cycles));
    chk("run_loading", 16'(Loading), 16'd0);
    chk("first_vld0", 16'(InstrValid), 16'd0);
  endtask

  initial begin
    last_exp = '{ins: 10'h000, vld: 1'b0};
    #12;
    chk("rst_ins", 16'(Instruction), 16'h000);
    chk("rst_vld", 16'(InstrValid), 16'd0);
    chk("rst_ready", 16'(LoadReady), 16'd0);
    chk("rst_loading", 16'(Loading), 16'd0);
    chk("rst_count", 16'(LoadCount), 16'd0);
    nReset = 1'b1;
    step();

    // Full 32-word load, no back-fill.
    for (int i = 0; i < 32; i++) ld_buf[i] = 10'(10'h3FF - i);
    load(32, 1'b1);
    wait_fill(0);
    fetch(5'd5, 1'b0, "full_a5");
    chk("full_a5_const", 16'(Instruction), 16'h3FA);

    // Stall holds the word for Addr=1 one extra cycle, nothing skipped.
    fetch(5'd0, 1'b0, "st_a0");
    fetch(5'd1, 1'b0, "st_a1");
    fetch(5'd2, 1'b1, "st_hold");
    fetch(5'd2, 1'b0, "st_a2");
    fetch(5'd3, 1'b0, "st_a3");
    fetch(5'd4, 1'b0, "st_a4");

    // Short load with back-fill.
    ld_buf[0] = 10'h101; ld_buf[1] = 10'h102; ld_buf[2] = 10'h103;
    load(3, 1'b1);
    wait_fill(29);
    fetch(5'd2, 1'b0, "short_a2");
    chk("short_a2_const", 16'(Instruction), 16'h103);
    fetch(5'd3, 1'b0, "short_a3");
    fetch(5'd31, 1'b0, "short_a31");
    fetch(5'd0, 1'b0, "short_a0");

    // LoadStart in RUN forces NOP/invalid even under Stall.
    Stall = 1'b1;
    LoadStart = 1'b1;
    step();
    LoadStart = 1'b0;
    Stall = 1'b0;
    chk("ldrun_ins", 16'(Instruction), 16'h000);
    chk("ldrun_vld", 16'(InstrValid), 16'd0);
    chk("ldrun_loading", 16'(Loading), 16'd1);

    // Restart mid-load after 10 words; restart beats LoadValid.
    for (int i = 0; i < 10; i++) begin
      LoadData = 10'(10'h2A0 + i);
      LoadValid = 1'b1;
      step();
    end
    chk("mid_count10", 16'(LoadCount), 16'd10);
    LoadStart = 1'b1;
    LoadData = 10'h155;
    step();
    LoadStart = 1'b0;
    LoadValid = 1'b0;
    chk("restart_count", 16'(LoadCount), 16'd0);
    chk("restart_loading", 16'(Loading), 16'd1);
    for (int i = 0; i < 4; i++) ld_buf[i] = 10'(10'h0A0 + i);
    load(4, 1'b0);
    wait_fill(28);
    for (int i = 0; i < 32; i++) fetch(5'(i), 1'b0, "restart_sweep");

    // Async reset in the middle of FILL.
    load(3, 1'b1);
    step(); step(); step();
    chk("fill_loading", 16'(Loading), 16'd1);
    nReset = 1'b0;
    #1;
    chk("rstfill_ins", 16'(Instruction), 16'h000);
    chk("rstfill_vld", 16'(InstrValid), 16'd0);
    chk("rstfill_loading", 16'(Loading), 16'd0);
    chk("rstfill_count", 16'(LoadCount), 16'd0);
    #2;
    nReset = 1'b1;
    step();
    Addr = 5'd2;
    step();
    chk("empty_fetch_ins", 16'(Instruction), 16'h000);
    chk("empty_fetch_vld", 16'(InstrValid), 16'd0);

    // 20-word load: DEPTH=20 instance goes straight to RUN, default one fills 12.
    for (int i = 0; i < 32; i++) ld_buf[i] = 10'(10'h200 + i);
    load(20, 1'b1);
    chk("d20_loading", 16'(s_Loading), 16'd0);
    chk("d20_count", 16'(s_LoadCount), 16'd20);
    wait_fill(12);
    fetch(5'd19, 1'b0, "d20_a19");
    chk("d20_a19_ins", 16'(s_Instruction), 16'h213);
    chk("d20_a19_vld", 16'(s_InstrValid), 16'd1);
    fetch(5'd25, 1'b0, "d20_a25");
    chk("d20_a25_ins", 16'(s_Instruction), 16'h000);
    chk("d20_a25_vld", 16'(s_InstrValid), 16'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
